// File: rtl/watch_time_scan_if.sv
// Button pulses into, and scan/display outputs out of, the watch time-keeping core.
// The core owns the slave side; whoever drives the buttons and reads the display owns the master side.
interface watch_time_scan_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] sel;
    logic [3:0] key;
    logic       sec_en;
    logic [2:0] control_dig;

    modport master (
        output btn_mode,
        output btn_inc,
        input  sel,
        input  key,
        input  sec_en,
        input  control_dig
    );

    modport slave (
        input  btn_mode,
        input  btn_inc,
        output sel,
        output key,
        output sec_en,
        output control_dig
    );
endinterface

// File: rtl/watch_time_scan.sv
// HH:MM:SS BCD time keeper with calibration FSM and 4-digit scan.
// Register outputs update one edge after their cause; key is a zero-latency mux of them. No backpressure: button pulses are always accepted.
module watch_time_scan #(
    parameter int CLK_HZ   = 24_000_000,
    parameter int SCAN_DIV = 24_000
) (
    input  logic             clk,
    input  logic             rst,
    watch_time_scan_if.slave wif
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);

    // Encoding doubles as the control_dig output code.
    typedef enum logic [2:0] {
        MODE_RUN = 3'd0,
        MODE_MU  = 3'd1,
        MODE_MT  = 3'd2,
        MODE_HU  = 3'd3,
        MODE_HT  = 3'd4
    } mode_e;

    mode_e         mode_q,   mode_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          sec_en_q, sec_en_d;
    logic [SW-1:0] scan_q,   scan_d;
    logic [1:0]    sel_q,    sel_d;

    logic [1:0]    hr_t_q, hr_t_d;
    logic [3:0]    hr_u_q, hr_u_d;
    logic [2:0]    mn_t_q, mn_t_d;
    logic [3:0]    mn_u_q, mn_u_d;
    logic [2:0]    sc_t_q, sc_t_d;
    logic [3:0]    sc_u_q, sc_u_d;

    logic          tick;
    logic          mode_step;
    logic          inc_req;
    logic          scan_wrap;
    logic [3:0]    key_w;

    always_comb begin : ctrl_decode
        tick      = (presc_q == PRESC_MAX);
        mode_step = wif.btn_mode;
        inc_req   = wif.btn_inc & ~wif.btn_mode;
    end

    always_comb begin : mode_next
        mode_d = mode_q;
        if (mode_step) begin
            unique case (mode_q)
                MODE_RUN: mode_d = MODE_HT;
                MODE_HT:  mode_d = MODE_HU;
                MODE_HU:  mode_d = MODE_MT;
                MODE_MT:  mode_d = MODE_MU;
                MODE_MU:  mode_d = MODE_RUN;
                default:  mode_d = MODE_RUN;
            endcase
        end
    end

    // Leaving calibration restarts the second so the first one after it is full length.
    always_comb begin : presc_next
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (mode_step && (mode_q == MODE_MU)) begin
            presc_d = '0;
        end
        sec_en_d = (presc_d < PRESC_HALF);
    end

    always_comb begin : time_next
        hr_t_d = hr_t_q;
        hr_u_d = hr_u_q;
        mn_t_d = mn_t_q;
        mn_u_d = mn_u_q;
        sc_t_d = sc_t_q;
        sc_u_d = sc_u_q;

        if (mode_q == MODE_RUN) begin
            if (tick) begin
                if (sc_u_q != 4'd9) begin
                    sc_u_d = sc_u_q + 4'd1;
                end else begin
                    sc_u_d = 4'd0;
                    if (sc_t_q != 3'd5) begin
                        sc_t_d = sc_t_q + 3'd1;
                    end else begin
                        sc_t_d = 3'd0;
                        if (mn_u_q != 4'd9) begin
                            mn_u_d = mn_u_q + 4'd1;
                        end else begin
                            mn_u_d = 4'd0;
                            if (mn_t_q != 3'd5) begin
                                mn_t_d = mn_t_q + 3'd1;
                            end else begin
                                mn_t_d = 3'd0;
                                if ((hr_t_q == 2'd2) && (hr_u_q == 4'd3)) begin
                                    hr_t_d = 2'd0;
                                    hr_u_d = 4'd0;
                                end else if (hr_u_q == 4'd9) begin
                                    hr_t_d = hr_t_q + 2'd1;
                                    hr_u_d = 4'd0;
                                end else begin
                                    hr_u_d = hr_u_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
            // Entering calibration starts the set minute from :00.
            if (mode_step) begin
                sc_t_d = 3'd0;
                sc_u_d = 4'd0;
            end
        end else if (inc_req) begin
            unique case (mode_q)
                MODE_HT: begin
                    hr_t_d = (hr_t_q == 2'd2) ? 2'd0 : hr_t_q + 2'd1;
                    if ((hr_t_d == 2'd2) && (hr_u_q > 4'd3)) begin
                        hr_u_d = 4'd3;
                    end
                end
                MODE_HU: begin
                    if (((hr_t_q == 2'd2) && (hr_u_q == 4'd3)) || (hr_u_q == 4'd9)) begin
                        hr_u_d = 4'd0;
                    end else begin
                        hr_u_d = hr_u_q + 4'd1;
                    end
                end
                MODE_MT: mn_t_d = (mn_t_q == 3'd5) ? 3'd0 : mn_t_q + 3'd1;
                MODE_MU: mn_u_d = (mn_u_q == 4'd9) ? 4'd0 : mn_u_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin : scan_next
        scan_wrap = (scan_q == SCAN_MAX);
        scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
        sel_d     = scan_wrap ? sel_q + 2'd1 : sel_q;
    end

    always_comb begin : key_mux
        key_w = 4'd0;
        unique case (sel_q)
            2'd0: key_w = {2'b00, hr_t_q};
            2'd1: key_w = hr_u_q;
            2'd2: key_w = {1'b0, mn_t_q};
            2'd3: key_w = mn_u_q;
            default: key_w = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_RUN;
            presc_q  <= '0;
            sec_en_q <= 1'b1;
            scan_q   <= '0;
            sel_q    <= 2'd0;
            hr_t_q   <= 2'd0;
            hr_u_q   <= 4'd0;
            mn_t_q   <= 3'd0;
            mn_u_q   <= 4'd0;
            sc_t_q   <= 3'd0;
            sc_u_q   <= 4'd0;
        end else begin
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            sec_en_q <= sec_en_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            hr_t_q   <= hr_t_d;
            hr_u_q   <= hr_u_d;
            mn_t_q   <= mn_t_d;
            mn_u_q   <= mn_u_d;
            sc_t_q   <= sc_t_d;
            sc_u_q   <= sc_u_d;
        end
    end

    assign wif.sel         = sel_q;
    assign wif.key         = key_w;
    assign wif.sec_en      = sec_en_q;
    assign wif.control_dig = mode_q;

endmodule

// File: tb/tb_watch_time_scan.sv
// Bench for watch_time_scan: time-of-day reference model checked every cycle, directed scenarios, random buttons.
module tb_watch_time_scan;

    localparam int CLK_HZ   = 10;
    localparam int SCAN_DIV = 2;

    logic clk = 1'b0;
    logic rst;

    watch_time_scan_if wif ();

    watch_time_scan #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wif(wif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: plain integers for hours/minutes/seconds, phase 0=run,1..4 = HT,HU,MT,MU.
    int m_h, m_m, m_s, m_presc, m_phase, m_scan, m_sel;
    bit m_sec_en;
    bit model_live = 1'b0;

    function automatic int cd_code(input int phase);
        case (phase)
            1:       return 4;
            2:       return 3;
            3:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int digit_of(input int h, input int m, input int idx);
        case (idx)
            0:       return h / 10;
            1:       return h % 10;
            2:       return m / 10;
            default: return m % 10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit tick;
        int tod;
        int ht, hu;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0;
            m_presc = 0; m_phase = 0; m_scan = 0; m_sel = 0;
            m_sec_en = 1'b1;
            model_live = 1'b1;
        end else if (model_live) begin
            tick = (m_presc == CLK_HZ - 1);
            if (wif.btn_mode && m_phase == 4) m_presc = 0;
            else                              m_presc = (m_presc + 1) % CLK_HZ;
            m_sec_en = (m_presc < CLK_HZ / 2);

            if (m_phase == 0 && tick) begin
                tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                m_s = tod % 60;
            end

            if (wif.btn_mode) begin
                if (m_phase == 0) m_s = 0;
                m_phase = (m_phase + 1) % 5;
            end else if (wif.btn_inc) begin
                ht = m_h / 10;
                hu = m_h % 10;
                case (m_phase)
                    1: begin
                        ht = (ht + 1) % 3;
                        if (ht == 2 && hu > 3) hu = 3;
                        m_h = ht * 10 + hu;
                    end
                    2: m_h = ht * 10 + (hu + 1) % ((ht == 2) ? 4 : 10);
                    3: m_m = ((m_m / 10 + 1) % 6) * 10 + m_m % 10;
                    4: m_m = (m_m / 10) * 10 + (m_m % 10 + 1) % 10;
                    default: ;
                endcase
            end

            m_scan = m_scan + 1;
            if (m_scan == SCAN_DIV) begin
                m_scan = 0;
                m_sel  = (m_sel + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("sel",         wif.sel,         m_sel);
            check("key",         wif.key,         digit_of(m_h, m_m, m_sel));
            check("sec_en",      wif.sec_en,      m_sec_en);
            check("control_dig", wif.control_dig, cd_code(m_phase));
        end
    end

    task automatic press(input bit mode, input bit inc);
        wif.btn_mode = mode;
        wif.btn_inc  = inc;
        @(negedge clk);
        wif.btn_mode = 1'b0;
        wif.btn_inc  = 1'b0;
    endtask

    // Walks the calibration FSM from RUN back to RUN, leaving seconds at 00.
    task automatic set_time(input int h, input int m);
        press(1'b1, 1'b0);
        for (int i = 0; i < 4 && (m_h / 10) != (h / 10); i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 11 && (m_h % 10) != (h % 10); i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 7 && (m_m / 10) != (m / 10); i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 11 && (m_m % 10) != (m % 10); i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask

    // Hand-computed digit expectations over a full scan; -1 skips a digit.
    task automatic expect_digits(input string name, input int e0, input int e1,
                                 input int e2, input int e3);
        int e;
        for (int i = 0; i < 8; i++) begin
            case (wif.sel)
                2'd0:    e = e0;
                2'd1:    e = e1;
                2'd2:    e = e2;
                default: e = e3;
            endcase
            if (e >= 0) check(name, wif.key, e);
            @(negedge clk);
        end
    endtask

    initial begin
        rst          = 1'b1;
        wif.btn_mode = 1'b0;
        wif.btn_inc  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset sel",         wif.sel,         0);
        check("reset key",         wif.key,         0);
        check("reset control_dig", wif.control_dig, 0);
        check("reset sec_en",      wif.sec_en,      1);
        rst = 1'b0;

        repeat (4) @(negedge clk);
        check("sec_en high 4", wif.sec_en, 1);
        @(negedge clk);
        check("sec_en fall 5", wif.sec_en, 0);
        repeat (4) @(negedge clk);
        check("sec_en low 9", wif.sec_en, 0);
        @(negedge clk);
        check("sec_en rise 10", wif.sec_en, 1);

        // 23:59:00 with a fresh second; 23:59:59 spans edges 590..599 after exit.
        set_time(23, 59);
        repeat (590) @(negedge clk);
        expect_digits("pre-midnight", 2, 3, 5, 9);
        repeat (7) @(negedge clk);
        expect_digits("midnight", 0, 0, 0, 0);

        press(1'b1, 1'b0); check("mode seq 1", wif.control_dig, 4);
        press(1'b1, 1'b0); check("mode seq 2", wif.control_dig, 3);
        press(1'b1, 1'b0); check("mode seq 3", wif.control_dig, 2);
        press(1'b1, 1'b0); check("mode seq 4", wif.control_dig, 1);
        press(1'b1, 1'b0); check("mode seq 5", wif.control_dig, 0);

        set_time(9, 0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1); expect_digits("ht 09->19", 1, 9, -1, -1);
        press(1'b0, 1'b1); expect_digits("ht 19->23 clamp", 2, 3, -1, -1);
        press(1'b0, 1'b1); expect_digits("ht 23->03", 0, 3, -1, -1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1); expect_digits("ht 03->23", 2, 3, -1, -1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1); expect_digits("hu 23->20", 2, 0, -1, -1);

        press(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            press(1'b0, 1'b1);
            expect_digits("mt step", -1, -1, i % 6, -1);
        end
        press(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        expect_digits("mu +3", -1, -1, 0, 3);
        for (int i = 0; i < 7; i++) press(1'b0, 1'b1);
        expect_digits("mu wrap no carry", 2, 0, 0, 0);
        press(1'b1, 1'b0);
        check("back to run", wif.control_dig, 0);

        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("mode beats inc", wif.control_dig, 3);
        expect_digits("inc dropped", 2, 0, -1, -1);
        press(1'b1, 1'b0);
        check("in mt", wif.control_dig, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in cal control_dig", wif.control_dig, 0);
        expect_digits("rst in cal time", 0, 0, 0, 0);

        // Busy button phase, then a long mostly-running phase to reach carries.
        for (int i = 0; i < 3000; i++) begin
            wif.btn_mode = ($urandom_range(0, 24) == 0);
            wif.btn_inc  = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        for (int i = 0; i < 6000; i++) begin
            wif.btn_mode = ($urandom_range(0, 499) == 0);
            wif.btn_inc  = ($urandom_range(0, 2) == 0);
            rst          = 1'b0;
            @(negedge clk);
        end
        wif.btn_mode = 1'b0;
        wif.btn_inc  = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
